// File: rtl/axi_rd_sched.sv
`default_nettype none
// =============================================================================
// Module      : axi_rd_sched
// Description : Round-robin two-requester burst scheduler driving the AXI4 read
//               master INIT_AXI_TXN/TXN_DONE/ERROR control interface.
//               Optional watchdog: define AXI_RD_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module axi_rd_sched #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BURST_LEN      = 16,
    parameter int NBURST_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESETN,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [NBURST_WIDTH-1:0] req0_nburst,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic [NBURST_WIDTH-1:0] req1_nburst,
    output logic                    done0,
    output logic                    done1,
    output logic                    err0,
    output logic                    err1,
    output logic                    busy,
    output logic                    grant,
    output logic                    txn_init,
    output logic [ADDR_WIDTH-1:0]   txn_addr,
    input  logic                    txn_done,
    input  logic                    txn_error
);

    localparam int C_BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] C_BURST_INC  = ADDR_WIDTH'(C_BURST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] C_ALIGN_MASK = ADDR_WIDTH'(C_BURST_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NBURST_WIDTH-1:0] cnt_q, cnt_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic                    txn_init_q, txn_init_d;
    logic [ADDR_WIDTH-1:0]   txn_addr_q, txn_addr_d;
    logic                    done0_q, done0_d;
    logic                    done1_q, done1_d;
    logic                    err0_q, err0_d;
    logic                    err1_q, err1_d;
    logic                    busy_q, busy_d;
    logic                    done_prev_q, done_prev_d;

    logic                    w_idle;
    logic                    w_win0;
    logic                    w_win1;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [NBURST_WIDTH-1:0] w_sel_nburst;
    logic                    w_misalign;
    logic                    w_done_rise;
    logic                    w_timeout;

    // Ties go to the requester that was not served most recently.
    assign w_idle       = (state_q == ST_IDLE) && M_AXI_ARESETN;
    assign w_win0       = w_idle && req0_valid && (!req1_valid || last_grant_q);
    assign w_win1       = w_idle && req1_valid && (!req0_valid || !last_grant_q);
    assign w_sel_addr   = w_win1 ? req1_addr : req0_addr;
    assign w_sel_nburst = w_win1 ? req1_nburst : req0_nburst;
    assign w_misalign   = (w_sel_addr & C_ALIGN_MASK) != '0;
    assign w_done_rise  = txn_done && !done_prev_q;

`ifdef AXI_RD_SCHED_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_TMO_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_ISSUE) begin
            tmo_d = '0;
        end else if (state_q == ST_WAIT) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign w_timeout = (state_q == ST_WAIT) && (tmo_q == C_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        txn_init_d   = 1'b0;
        txn_addr_d   = txn_addr_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        done_prev_d  = txn_done;

        case (state_q)
            ST_IDLE: begin
                if (w_win0 || w_win1) begin
                    grant_d      = w_win1;
                    last_grant_d = w_win1;
                    addr_d       = w_sel_addr;
                    cnt_d        = w_sel_nburst;
                    if (w_sel_nburst == '0 || w_misalign) begin
                        state_d = ST_RESP;
                        done0_d = !w_win1;
                        done1_d = w_win1;
                        err0_d  = !w_win1 && w_misalign;
                        err1_d  = w_win1 && w_misalign;
                    end else begin
                        state_d    = ST_ISSUE;
                        txn_init_d = 1'b1;
                        txn_addr_d = w_sel_addr;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A level still high from the previous burst is not a completion.
                if (w_done_rise) begin
                    if (txn_error || cnt_q == NBURST_WIDTH'(1)) begin
                        state_d = ST_RESP;
                        done0_d = !grant_q;
                        done1_d = grant_q;
                        err0_d  = !grant_q && txn_error;
                        err1_d  = grant_q && txn_error;
                    end else begin
                        state_d    = ST_ISSUE;
                        addr_d     = addr_q + C_BURST_INC;
                        cnt_d      = cnt_q - 1'b1;
                        txn_init_d = 1'b1;
                        txn_addr_d = addr_q + C_BURST_INC;
                    end
                end else if (w_timeout) begin
                    state_d = ST_RESP;
                    done0_d = !grant_q;
                    done1_d = grant_q;
                    err0_d  = !grant_q;
                    err1_d  = grant_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            txn_init_q   <= 1'b0;
            txn_addr_q   <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            txn_init_q   <= txn_init_d;
            txn_addr_q   <= txn_addr_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            busy_q       <= busy_d;
            done_prev_q  <= done_prev_d;
        end
    end

    assign req0_ready = w_win0;
    assign req1_ready = w_win1;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign err0       = err0_q;
    assign err1       = err1_q;
    assign busy       = busy_q;
    assign grant      = grant_q;
    assign txn_init   = txn_init_q;
    assign txn_addr   = txn_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_sched.sv
`default_nettype none
// =============================================================================
// Module      : tb_axi_rd_sched
// Description : Directed self-checking bench for axi_rd_sched (default build).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_axi_rd_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_addr, req1_addr;
    logic [7:0]  req0_nburst, req1_nburst;
    logic        done0, done1, err0, err1, busy, grant, txn_init;
    logic [31:0] txn_addr;
    logic        txn_done, txn_error;

    int n_assert = 0;
    int n_fail   = 0;
    int n_init   = 0;
    int init_base;

    always #5 clk = ~clk;

    always @(negedge clk) if (txn_init === 1'b1) n_init++;

    axi_rd_sched dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_addr     (req0_addr),
        .req0_nburst   (req0_nburst),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_addr     (req1_addr),
        .req1_nburst   (req1_nburst),
        .done0         (done0),
        .done1         (done1),
        .err0          (err0),
        .err1          (err1),
        .busy          (busy),
        .grant         (grant),
        .txn_init      (txn_init),
        .txn_addr      (txn_addr),
        .txn_done      (txn_done),
        .txn_error     (txn_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_init"},  32'(txn_init), 0);
        check({tag, "_addr"},  txn_addr, 0);
        check({tag, "_done"},  {30'd0, done1, done0}, 0);
        check({tag, "_err"},   {30'd0, err1, err0}, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_addr = 0; req1_addr = 0; req0_nburst = 0; req1_nburst = 0;
        txn_done = 0; txn_error = 0;
        tick(); tick();
        check_idle_outs("reset");
        check("reset_ready", {30'd0, req1_ready, req0_ready}, 0);
        rst_n = 1'b1;
        tick();

        // 3-burst fetch on requester 0
        init_base = n_init;
        req0_valid = 1; req0_addr = 32'h1000; req0_nburst = 3;
        #1;
        check("t1_ready", {30'd0, req1_ready, req0_ready}, 32'b01);
        tick();
        req0_valid = 0;
        check("t1_init0", 32'(txn_init), 1);
        check("t1_addr0", txn_addr, 32'h1000);
        check("t1_busy", 32'(busy), 1);
        check("t1_grant", 32'(grant), 0);
        tick();
        check("t1_init_off", 32'(txn_init), 0);
        tick();
        txn_done = 1; tick(); txn_done = 0;
        check("t1_init1", 32'(txn_init), 1);
        check("t1_addr1", txn_addr, 32'h1040);
        tick(); tick();
        txn_done = 1; tick(); txn_done = 0;
        check("t1_init2", 32'(txn_init), 1);
        check("t1_addr2", txn_addr, 32'h1080);
        check("t1_nodone_early", 32'(done0), 0);
        tick(); tick();
        txn_done = 1; tick(); txn_done = 0;
        check("t1_done", {28'd0, err1, err0, done1, done0}, 32'b0001);
        check("t1_init_at_done", 32'(txn_init), 0);
        tick();
        check("t1_done_pulse", 32'(done0), 0);
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_ninit", 32'(n_init - init_base), 3);

        // Error on the second completion of a 4-burst fetch on requester 1
        init_base = n_init;
        req1_valid = 1; req1_addr = 32'h2000; req1_nburst = 4;
        #1;
        check("t3_ready", {30'd0, req1_ready, req0_ready}, 32'b10);
        tick();
        req1_valid = 0;
        check("t3_grant", 32'(grant), 1);
        check("t3_addr0", txn_addr, 32'h2000);
        tick();
        txn_done = 1; tick(); txn_done = 0;
        check("t3_addr1", txn_addr, 32'h2040);
        tick();
        txn_done = 1; txn_error = 1; tick(); txn_done = 0; txn_error = 0;
        check("t3_done_err", {28'd0, err1, err0, done1, done0}, 32'b1010);
        tick();
        check("t3_pulse_end", {28'd0, err1, err0, done1, done0}, 0);
        check("t3_ninit", 32'(n_init - init_base), 2);

        // Zero-burst and misaligned requests complete without a transaction
        init_base = n_init;
        req0_valid = 1; req0_addr = 32'h3000; req0_nburst = 0;
        tick();
        req0_valid = 0;
        check("t4_zero_done", {28'd0, err1, err0, done1, done0}, 32'b0001);
        check("t4_zero_init", 32'(txn_init), 0);
        tick();
        check("t4_zero_busy", 32'(busy), 0);
        req0_valid = 1; req0_addr = 32'h1004; req0_nburst = 2;
        tick();
        req0_valid = 0;
        check("t4_mis_done", {28'd0, err1, err0, done1, done0}, 32'b0101);
        tick();
        check("t4_ninit", 32'(n_init - init_base), 0);

        // Reset, then both requesters contend continuously
        rst_n = 0; tick(); rst_n = 1; tick();
        req0_valid = 1; req0_addr = 32'h4000; req0_nburst = 1;
        req1_valid = 1; req1_addr = 32'h5000; req1_nburst = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t2_ready%0d", i), {30'd0, req1_ready, req0_ready},
                  (i % 2 == 1) ? 32'b10 : 32'b01);
            tick();
            check($sformatf("t2_grant%0d", i), 32'(grant), 32'(i % 2));
            check($sformatf("t2_addr%0d", i), txn_addr, (i % 2 == 1) ? 32'h5000 : 32'h4000);
            tick();
            txn_done = 1; tick(); txn_done = 0;
            check($sformatf("t2_done%0d", i), {30'd0, done1, done0},
                  (i % 2 == 1) ? 32'b10 : 32'b01);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        tick();

        // Stale done level held across the next ISSUE is not a completion
        req0_valid = 1; req0_addr = 32'h6000; req0_nburst = 2;
        tick();
        req0_valid = 0;
        tick();
        txn_done = 1; tick();
        check("t5_addr1", txn_addr, 32'h6040);
        for (int i = 0; i < 10; i++) tick();
        check("t5_stale_done", 32'(done0), 0);
        check("t5_stale_busy", 32'(busy), 1);
        check("t5_stale_init", 32'(txn_init), 0);
        txn_done = 0; tick();
        txn_done = 1; tick(); txn_done = 0;
        check("t5_real_done", {28'd0, err1, err0, done1, done0}, 32'b0001);
        tick();

        // Reset during WAIT drops the request silently
        req1_valid = 1; req1_addr = 32'h7000; req1_nburst = 1;
        tick();
        req1_valid = 0;
        tick();
        check("t6_in_wait", 32'(busy), 1);
        rst_n = 0;
        #1;
        check_idle_outs("t6_rst");
        tick();
        rst_n = 1;
        tick();
        txn_done = 1; tick(); tick(); txn_done = 0;
        check("t6_no_done", {28'd0, err1, err0, done1, done0}, 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_init", 32'(txn_init), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_rd_sched.md
# axi_rd_sched

Two-requester burst scheduler that sequences the AXI4 read master (`INIT_AXI_TXN` / `TXN_DONE` / `ERROR` control interface) in the rectification datapath. Each requester submits a multi-burst line fetch as a base address plus a burst count. The block arbitrates round-robin and issues one master transaction per burst at consecutive burst-sized addresses. It reports completion and error per requester, so the left and right image fetch engines can share one master port.

## Interface
- `ADDR_WIDTH`, 32, byte address width, matches the master's `C_M_AXI_ADDR_WIDTH`
- `DATA_WIDTH`, 32, master data width in bits
- `BURST_LEN`, 16, beats per master burst
- `NBURST_WIDTH`, 8, width of the burst-count field
- `TIMEOUT_CYCLES`, 4096, watchdog limit per burst; used only with `AXI_RD_SCHED_TIMEOUT_EN`

Ports:
- `M_AXI_ACLK`  in  1  sole clock
- `M_AXI_ARESETN`  in  1  reset, asynchronous, active-low
- `req0_valid` / `req1_valid`  in  1  fetch request
- `req0_ready` / `req1_ready`  out  1  request accepted when valid&ready
- `req0_addr` / `req1_addr`  in  ADDR_WIDTH  first burst address, BURST_BYTES-aligned
- `req0_nburst` / `req1_nburst`  in  NBURST_WIDTH  number of bursts
- `done0` / `done1`  out  1  one-cycle completion pulse
- `err0` / `err1`  out  1  one-cycle pulse, coincident with done, request failed
- `busy`  out  1  state ≠ IDLE
- `grant`  out  1  owner of current request (0/1)
- `txn_init`  out  1  one-cycle start pulse, drives master `INIT_AXI_TXN`
- `txn_addr`  out  ADDR_WIDTH  burst address to master
- `txn_done`  in  1  master `TXN_DONE` (level)
- `txn_error`  in  1  master `ERROR` (level)

## Operation
- BURST_BYTES = BURST_LEN*DATA_WIDTH/8 (default 64). Address arithmetic is modulo 2^ADDR_WIDTH; wrap is not flagged.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE behaviour:
  - `reqN_ready` is combinational: high only for the arbitration winner.
  - If only one request is valid, that requester wins.
  - If both are valid, the requester not served last wins. `last_grant` resets to 1, so requester 0 wins the first tie.
- On acceptance, the block latches addr, nburst and owner, and updates `grant` and `last_grant`.
  - nburst=0: go to RESP, with no transaction issued.
  - Misaligned addr (low log2(BURST_BYTES) bits ≠ 0): go to RESP with err.
  - Otherwise: go to ISSUE.
- ISSUE: assert `txn_init` for exactly one cycle, with `txn_addr` = current address, then go to WAIT.
- WAIT: completion is the rising edge of `txn_done` (registered previous value), so a stale high level from a prior transaction is ignored. On completion:
  - If `txn_error`=1, go to RESP with err and abort the remaining bursts.
  - Else if the remaining count = 1, go to RESP.
  - Else add BURST_BYTES to the address, decrement the count and go to ISSUE.
- RESP: pulse `doneN` (and `errN` if flagged) for the owner, then go to IDLE.
- A new request is accepted only in IDLE. No queueing.

## Timing
- Reset values: all outputs 0; `last_grant`=1; state IDLE; `txn_done` edge register 0.
- Handshake at cycle T: `txn_init`=1 at T+1, state WAIT from T+2.
- Completion edge seen at cycle C:
  - Next burst: `txn_init` at C+1.
  - Last burst: `doneN` at C+1; `reqN_ready` can be high again at C+2.
- Request with nburst=0 or misaligned addr: done (and err) at T+1.
- `txn_addr` is registered and stable from ISSUE until the next ISSUE.
- `grant` is valid from T+1 until RESP ends.
- Reset asserted mid-request: immediate return to IDLE, no done/err pulse, request dropped.
- Requester inputs are sampled only at the handshake.

## Configuration
- `AXI_RD_SCHED_TIMEOUT_EN` defined:
  - A counter clears on ISSUE and increments in WAIT.
  - Reaching TIMEOUT_CYCLES without completion → RESP with err, abort the request.
- Not defined: WAIT waits indefinitely, and the counter logic is absent.

## Test plan
- req0 addr=0x1000, nburst=3 → `txn_init` pulses with `txn_addr` 0x1000, 0x1040, 0x1080, each after a `txn_done` rise; `done0` 1 cycle after the third rise; `err0`=0.
- req0 and req1 valid together from reset → req0 granted first, req1 next; with both still valid, ownership alternates 0,1,0,1.
- `txn_error`=1 at the second completion of nburst=4 → `done1` and `err1` together; only 2 `txn_init` pulses.
- nburst=0 → `done0` at T+1, no `txn_init`; addr=0x1004 → `done0`+`err0` at T+1, no `txn_init`.
- `txn_done` held high across a new ISSUE and never re-risen → no completion; with `AXI_RD_SCHED_TIMEOUT_EN`, err at TIMEOUT_CYCLES.
- `M_AXI_ARESETN` low during WAIT → all outputs 0 immediately, `busy`=0, no done pulse after release.
